hamming_dec_engine: RTL
=======================

# hamming_dec_engine

Memory-side SECDED decoder sequencer for the 16-bit Hamming code produced by program 1. On a `req` pulse it reads `NWORDS` encoded words from data memory and corrects any single-bit error. It flags double-bit errors and writes each recovered 11-bit message plus a 2-bit status back to memory, then raises `ack`. It sits beside the core on the data-memory port and answers the same req/ack handshake the top level uses.

## Interface
- `IN_BASE`, default 64: byte address of the first encoded word's low byte.
- `OUT_BASE`, default 94: byte address of the first decoded word's low byte.
- `NWORDS`, default 15: number of words per run (1..64).
- `clk` in, 1: rising-edge clock.
- `reset` in, 1: asynchronous, active-low reset; `reset`=0 forces the reset state immediately.
- `req` in, 1: start request, sampled on `clk`.
- `ack` out, 1: run complete, registered.
- `mem_addr` out, 8: byte address to data memory.
- `mem_rdata` in, 8: memory read data, combinational in `mem_addr`.
- `mem_wdata` out, 8: memory write data.
- `mem_we` out, 1: write enable; memory writes at the `clk` edge while this is high.
- `single_cnt` out, 8: present only with `HAMDEC_STATS_EN`; count of corrected words.
- `double_cnt` out, 8: present only with `HAMDEC_STATS_EN`; count of double-error words.

## Operation
- States: IDLE, RD_LO, RD_HI, DECODE, WR_LO, WR_HI, DONE. The 6-bit word index is `w`.
- IDLE: if `req`=1, clear `w` and go to RD_LO.
- RD_LO: `mem_addr` = `IN_BASE`+2w; latch `mem_rdata` into `cw[7:0]`.
- RD_HI: `mem_addr` = `IN_BASE`+2w+1; latch into `cw[15:8]`.
- Code layout: bit 0 is `p16`, the overall parity. Bits 1, 2, 4 and 8 are `p1`, `p2`, `p4` and `p8`. Data bits sit at bits 3, 5, 6, 7 and 9..15, giving `d1`..`d11` in ascending order.
- DECODE computes:
  - `s[3:0]` = XOR of the indices i in 1..15 where `cw[i]`=1.
  - `P` = XOR of `cw[15:0]`.
- DECODE outcomes:
  - `s`=0 and `P`=0: no error; `flags`=00.
  - `P`=1: single error at bit `s` (`s`=0 means `p16` itself). Invert that bit and set `flags`=01.
  - `s`≠0 and `P`=0: double error. Leave data uncorrected and set `flags`=10.
  - `flags`=11 is never produced.
- Result registers are latched at the end of DECODE.
- WR_LO: `mem_addr` = `OUT_BASE`+2w, `mem_wdata` = `d[8:1]`, `mem_we`=1.
- WR_HI: `mem_addr` = `OUT_BASE`+2w+1, `mem_wdata` = {`flags`, 3'b000, `d[11:9]`}, `mem_we`=1.
  - If `w`=`NWORDS`-1, go to DONE; otherwise increment `w` and go to RD_LO.
- DONE: `ack`=1. On `req`=1, clear `ack` and `w` and go to RD_LO, which starts a new run.
- `req` is ignored in every state except IDLE and DONE.
- Address arithmetic is 8-bit and wraps modulo 256. No range check is performed.

## Timing
- Reset values:
  - state = IDLE, `w`=0, `ack`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - `single_cnt`=0, `double_cnt`=0.
- In IDLE and DONE, `mem_addr`=0, `mem_we`=0 and `mem_wdata`=0.
- Each state lasts exactly 1 cycle, so each word takes 5 cycles.
- Latency: with `req` sampled high at edge 0, `ack` is high after edge 5·`NWORDS`+1, which is edge 76 at the defaults.
- Writes for word w land at the edges ending WR_LO and WR_HI.
- Memory reads have no wait states. `mem_rdata` must be valid within the same cycle.
- `ack` is a level signal. It stays high until `req` is sampled high in DONE, and it is never high outside DONE.
- A 1-cycle `req` pulse is sufficient. Holding `req` high across DONE causes back-to-back runs.
- Reset mid-run: return to IDLE asynchronously and drop `mem_we` immediately. Bytes already written stay as they are, and no partial write completes.
- Input and output regions may overlap. Word w's reads always complete before its writes.

## Configuration
- `HAMDEC_STATS_EN` defined:
  - Adds the `single_cnt` and `double_cnt` ports.
  - Both counters clear on the edge that starts a run.
  - `single_cnt` increments on each `flags`=01 result; `double_cnt` increments on each `flags`=10 result.
  - Both saturate at 255 and hold their values after `ack` rises.
- `HAMDEC_STATS_EN` undefined: the ports and counter logic are absent. All other behaviour is identical.

## Test plan
- Clean word: message 11'h5A3 encoded without error → output bytes 8'hA3 and 8'h05, with `flags`=00; `ack` after 76 cycles.
- Single data error: same code word with bit 5 flipped → bytes 8'hA3 and 8'h05, with `flags`=01 in the high byte (8'h45).
- Parity-only error: bit 0 (`p16`) flipped → data unchanged, `flags`=01; bit 8 (`p8`) flipped → data unchanged, `flags`=01.
- Double error: bits 3 and 12 flipped → high byte[7:6]=10; data bytes are the raw uncorrected `d` fields.
- Reset mid-run: drive `reset` low during WR_LO of word 7 → `mem_we` drops the same cycle and `ack`=0. Words 0..6 are written, words 8..14 are untouched. A new `req` then completes all 15 words.
- With `HAMDEC_STATS_EN`: 15 words split as 5 clean, 7 single-error, 3 double-error → `single_cnt`=7 and `double_cnt`=3 at `ack`. Both counters clear on the next run.

Source files
------------

// File: rtl/hamming_dec_engine_if.sv
// Bus bundle for hamming_dec_engine: start/complete handshake plus the
// byte-wide data-memory port.
//
// Handshake: req is a start request sampled on the rising clock edge while
// the engine is in IDLE or DONE and ignored otherwise. A one-cycle pulse is
// enough. ack is a registered level that rises once every word of the run
// has been written back. It stays high until req is sampled high again,
// which clears it and starts the next run. Memory reads are combinational in
// mem_addr with no wait states. A write lands on the rising edge while
// mem_we is high.
interface hamming_dec_engine_if;
  logic       req;
  logic       ack;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] mem_wdata;
  logic       mem_we;

  // Engine side.
  modport master (
    input  req,
    input  mem_rdata,
    output ack,
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  // Requester / memory side.
  modport slave (
    output req,
    output mem_rdata,
    input  ack,
    input  mem_addr,
    input  mem_wdata,
    input  mem_we
  );
endinterface

// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine: SECDED decoder sequencer for 16-bit Hamming words.
// It reads NWORDS encoded words starting at IN_BASE and corrects single-bit
// errors. Double-bit errors are flagged and left uncorrected. For each word
// it writes {flags, 3'b000, d[11:9]} and d[8:1] starting at OUT_BASE, then
// raises ack.
// Optional feature macro: HAMDEC_STATS_EN adds the single_cnt/double_cnt
// saturating result counters.
module hamming_dec_engine #(
  parameter int unsigned IN_BASE  = 64,
  parameter int unsigned OUT_BASE = 94,
  parameter int unsigned NWORDS   = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  hamming_dec_engine_if.master        bus,
  output logic [2:0]                  dbg_state
`ifdef HAMDEC_STATS_EN
  ,
  output logic [7:0]                  single_cnt,
  output logic [7:0]                  double_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    DECODE = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [7:0] IN_B   = 8'(IN_BASE);
  localparam logic [7:0] OUT_B  = 8'(OUT_BASE);
  localparam logic [5:0] W_LAST = 6'(NWORDS - 1);

  state_t      state, state_nx;
  logic [5:0]  w;
  logic [15:0] cw;        // raw word after the reads, corrected after DECODE
  logic [1:0]  flags_q;
  logic [3:0]  syn;
  logic        par;
  logic [15:0] cw_fix;
  logic [1:0]  flags_nx;
  logic        start;
  logic [7:0]  in_addr, out_addr;

  assign dbg_state = state;
  assign start     = ((state == IDLE) || (state == DONE)) && bus.req;
  assign in_addr   = IN_B + {1'b0, w, 1'b0};
  assign out_addr  = OUT_B + {1'b0, w, 1'b0};

  // State register; reset drops the engine to IDLE immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and memory-port drive. The memory outputs are decoded from
  // state, so an asynchronous reset kills mem_we in the same cycle.
  always_comb begin
    state_nx      = state;
    bus.mem_addr  = 8'h00;
    bus.mem_wdata = 8'h00;
    bus.mem_we    = 1'b0;
    case (state)
      IDLE:   if (bus.req) state_nx = RD_LO;
      RD_LO: begin
        bus.mem_addr = in_addr;
        state_nx     = RD_HI;
      end
      RD_HI: begin
        bus.mem_addr = in_addr + 8'd1;
        state_nx     = DECODE;
      end
      DECODE: state_nx = WR_LO;
      WR_LO: begin
        bus.mem_addr  = out_addr;
        bus.mem_wdata = {cw[12:9], cw[7:5], cw[3]};
        bus.mem_we    = 1'b1;
        state_nx      = WR_HI;
      end
      WR_HI: begin
        bus.mem_addr  = out_addr + 8'd1;
        bus.mem_wdata = {flags_q, 3'b000, cw[15:13]};
        bus.mem_we    = 1'b1;
        state_nx      = (w == W_LAST) ? DONE : RD_LO;
      end
      DONE:   if (bus.req) state_nx = RD_LO;
      default: state_nx = IDLE;
    endcase
  end

  // Syndrome is the XOR of the set-bit positions. Odd overall parity means a
  // single error at position syn, where syn=0 is p16 itself.
  always_comb begin
    syn = 4'd0;
    for (int i = 1; i < 16; i++) begin
      if (cw[i]) syn = syn ^ 4'(i);
    end
    par      = ^cw;
    cw_fix   = cw;
    flags_nx = 2'b00;
    if (par) begin
      cw_fix[syn] = ~cw[syn];
      flags_nx    = 2'b01;
    end else if (syn != 4'd0) begin
      flags_nx = 2'b10;
    end
  end

  // Word index, code-word capture and result latch (corrected word + flags).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w       <= 6'd0;
      cw      <= 16'h0000;
      flags_q <= 2'b00;
    end else begin
      if (start)                              w <= 6'd0;
      else if (state == WR_HI && w != W_LAST) w <= w + 6'd1;
      if (state == RD_LO)  cw[7:0]  <= bus.mem_rdata;
      if (state == RD_HI)  cw[15:8] <= bus.mem_rdata;
      if (state == DECODE) begin
        cw      <= cw_fix;
        flags_q <= flags_nx;
      end
    end
  end

  // ack rises one cycle into DONE and is cleared by the req that leaves DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bus.ack <= 1'b0;
    else        bus.ack <= (state == DONE) && !bus.req;
  end

`ifdef HAMDEC_STATS_EN
  // Saturating result counters, cleared on the edge that starts a run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      single_cnt <= 8'd0;
      double_cnt <= 8'd0;
    end else if (start) begin
      single_cnt <= 8'd0;
      double_cnt <= 8'd0;
    end else if (state == DECODE) begin
      if (flags_nx == 2'b01 && single_cnt != 8'hFF) single_cnt <= single_cnt + 8'd1;
      if (flags_nx == 2'b10 && double_cnt != 8'hFF) double_cnt <= double_cnt + 8'd1;
    end
  end
`endif

endmodule
